// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Inhibits the bus, issues a request-to-send, then shifts one command byte
// (start, 8 data bits LSB first, odd parity, stop) out on the falling edges
// generated by the device, and finally waits for the device ACK.
// The bus is driven only through active-high pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);

  localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_REQUEST  = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_ACK_WAIT = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  logic [2:0]    state_q,    state_d;
  logic [8:0]    shift_q,    shift_d;    // {stop, parity, data}, LSB goes out first
  logic [TW-1:0] timer_q,    timer_d;
  logic [3:0]    cnt_q,      cnt_d;      // falls seen since the request
  logic          clk_prev_q, clk_prev_d;
  logic          ack_q,      ack_d;
  logic          clk_oe_q,   clk_oe_d;
  logic          data_oe_q,  data_oe_d;
  logic          done_q,     done_d;
  logic          ack_err_q,  ack_err_d;
  logic          timeout_q,  timeout_d;

  logic fall;

  assign fall        = clk_prev_q & ~ps2_clk_in;
  assign ready       = (state_q == S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

  // Next-state logic: everything advances only on enabled cycles, except the
  // completion pulse and its flags, which always clear after one clk cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_d    = state_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    clk_prev_d = clk_prev_q;
    ack_d      = ack_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    timeout_d  = 1'b0;

    if (enable) begin
      clk_prev_d = ps2_clk_in;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_d   = {1'b1, ~^data, data};
            timer_d   = INHIBIT_LOAD;
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            state_d   = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (timer_q == '0) begin
            // Release clock and pull data low: the start bit doubles as the request.
            timer_d   = TIMEOUT_LOAD;
            cnt_d     = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            state_d   = S_REQUEST;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
        default: begin
          // Device-clocked phase: the timeout overrides any bus activity.
          if (timer_q == '0) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            timer_d = timer_q - TIMER_ONE;
            case (state_q)
              S_REQUEST, S_SHIFT: begin
                if (fall) begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = {1'b1, shift_q[8:1]};
                  cnt_d     = cnt_q + 4'd1;
                  state_d   = (cnt_q == 4'd9) ? S_ACK_WAIT : S_SHIFT;
                end
              end
              S_ACK_WAIT: begin
                if (fall) begin
                  ack_d   = ~ps2_data_in;
                  state_d = S_RELEASE;
                end
              end
              S_RELEASE: begin
                if (ps2_clk_in && ps2_data_in) begin
                  clk_oe_d  = 1'b0;
                  data_oe_d = 1'b0;
                  done_d    = 1'b1;
                  ack_err_d = ~ack_q;
                  state_d   = S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // State registers; reset releases both bus lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      clk_prev_q <= 1'b1;
      ack_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      clk_prev_q <= clk_prev_d;
      ack_q      <= ack_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a simple device that
// clocks the frame and optionally ACKs, table-driven frames, randomized
// frames checked against a parity/bit-order model, plus timeout and reset
// sequences.
module tb_ps2_host_tx;

  localparam int INH = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       start;
  logic [7:0] data;
  logic       ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       ack_err;
  logic       timeout;

  // Device side of the open-drain bus: the line is low if either side pulls.
  logic dev_clk;
  logic dev_data;
  logic clk_line;
  logic data_line;
  assign clk_line  = dev_clk  & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .data       (data),
    .ready      (ready),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Clock-enable pattern and completion-pulse bookkeeping.
  bit   slow = 1'b0;
  int   cyc = 0;
  logic last_en;
  int   done_cnt = 0;
  logic d_ack_err, d_timeout, d_ready, d_clk_oe, d_data_oe;

  typedef struct {
    logic [7:0] d;
    bit         ack;
    bit         slow;
    bit         poke;
    bit         par;
    bit         ack_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clk cycle: choose enable for the coming edge, sample #1 after it.
  task automatic step();
    cyc++;
    enable = slow ? (cyc % 3 == 0) : 1'b1;
    @(posedge clk);
    last_en = enable;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      d_ack_err = ack_err;
      d_timeout = timeout;
      d_ready   = ready;
      d_clk_oe  = ps2_clk_oe;
      d_data_oe = ps2_data_oe;
    end
  endtask

  // Issue start and follow the inhibit phase; leaves the DUT in REQUEST.
  task automatic begin_frame(input logic [7:0] d, input string tag);
    int n;
    int en_n;
    start = 1'b1;
    data  = d;
    n = 0;
    do begin step(); n++; end while (ready && n < 10);
    start = 1'b0;
    data  = 8'h00;
    check($sformatf("%s accept ready", tag), ready, 0);
    check($sformatf("%s inhibit clk_oe", tag), ps2_clk_oe, 1);
    check($sformatf("%s inhibit data_oe", tag), ps2_data_oe, 0);
    n = 0;
    en_n = 0;
    while (ps2_clk_oe && n < 100) begin
      step();
      n++;
      if (last_en) en_n++;
    end
    check($sformatf("%s inhibit enabled cycles", tag), en_n, INH);
    check($sformatf("%s inhibit clk cycles", tag), n, slow ? 3 * INH : INH);
    check($sformatf("%s request data_oe", tag), ps2_data_oe, 1);
  endtask

  // Full frame with the device model; rst_fall>0 aborts with a reset after that fall.
  task automatic frame(input logic [7:0] d, input bit dev_ack, input bit exp_par,
                       input bit exp_ack_err, input bit poke, input int rst_fall,
                       input string tag);
    logic [9:0] exp_bits;
    int hp;
    int n;
    exp_bits = {1'b1, exp_par, d};
    hp = slow ? 3 : 2;
    done_cnt = 0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    begin_frame(d, tag);
    repeat (hp) step();
    for (int f = 1; f <= 11; f++) begin
      if (f == 11) dev_data = dev_ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (hp) step();
      if (f <= 10)
        check($sformatf("%s bit after fall %0d", tag, f), data_line, exp_bits[f-1]);
      if (poke && f == 5) begin
        start = 1'b1;
        data  = 8'hC3;
        step();
        start = 1'b0;
        data  = 8'h00;
      end
      if (rst_fall == f) begin
        #2;
        rst = 1'b1;
        #1;
        check($sformatf("%s async clk_oe", tag), ps2_clk_oe, 0);
        check($sformatf("%s async data_oe", tag), ps2_data_oe, 0);
        check($sformatf("%s async ready", tag), ready, 1);
        #1;
        rst = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (4) step();
        check($sformatf("%s no done after reset", tag), done_cnt, 0);
        return;
      end
      dev_clk = 1'b1;
      repeat (hp) step();
    end
    dev_data = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 40) begin step(); n++; end
    repeat (3) step();
    check($sformatf("%s done pulses", tag), done_cnt, 1);
    check($sformatf("%s ack_err", tag), d_ack_err, exp_ack_err);
    check($sformatf("%s timeout flag", tag), d_timeout, 0);
    check($sformatf("%s ready with done", tag), d_ready, 1);
    check($sformatf("%s oe with done", tag), {d_clk_oe, d_data_oe}, 0);
    check($sformatf("%s idle after", tag), {ready, ps2_clk_oe}, 2'b10);
  endtask

  initial begin
    vecs[0] = '{d: 8'h5A, ack: 1'b1, slow: 1'b0, poke: 1'b0, par: 1'b1, ack_err: 1'b0};
    vecs[1] = '{d: 8'h01, ack: 1'b1, slow: 1'b0, poke: 1'b0, par: 1'b0, ack_err: 1'b0};
    vecs[2] = '{d: 8'hFF, ack: 1'b1, slow: 1'b0, poke: 1'b0, par: 1'b1, ack_err: 1'b0};
    vecs[3] = '{d: 8'h00, ack: 1'b1, slow: 1'b0, poke: 1'b0, par: 1'b1, ack_err: 1'b0};
    vecs[4] = '{d: 8'h5A, ack: 1'b0, slow: 1'b0, poke: 1'b0, par: 1'b1, ack_err: 1'b1};
    vecs[5] = '{d: 8'hA7, ack: 1'b1, slow: 1'b1, poke: 1'b1, par: 1'b0, ack_err: 1'b0};

    rst      = 1'b1;
    enable   = 1'b1;
    start    = 1'b0;
    data     = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #1;
    check("reset ready", ready, 1);
    check("reset clk_oe", ps2_clk_oe, 0);
    check("reset data_oe", ps2_data_oe, 0);
    check("reset done", done, 0);
    check("reset ack_err", ack_err, 0);
    check("reset timeout", timeout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step();

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      slow = vecs[i].slow;
      frame(vecs[i].d, vecs[i].ack, vecs[i].par, vecs[i].ack_err, vecs[i].poke, 0,
            $sformatf("vec%0d", i));
    end
    slow = 1'b0;

    // Device never clocks: timeout 64 enabled cycles after entering REQUEST.
    begin
      int n;
      done_cnt = 0;
      begin_frame(8'h3C, "tmo");
      n = 0;
      while (done_cnt == 0 && n < 200) begin step(); n++; end
      check("tmo cycles to done", n, TMO);
      check("tmo timeout flag", d_timeout, 1);
      check("tmo ack_err", d_ack_err, 0);
      check("tmo ready", d_ready, 1);
      check("tmo oe", {d_clk_oe, d_data_oe}, 0);
      // start presented in the done cycle is accepted.
      start = 1'b1;
      data  = 8'h00;
      step();
      start = 1'b0;
      check("start in done cycle ready", ready, 0);
      check("start in done cycle clk_oe", ps2_clk_oe, 1);
      done_cnt = 0;
      n = 0;
      while (done_cnt == 0 && n < 200) begin step(); n++; end
      check("second tmo flag", d_timeout, 1);
      step();
    end

    // Reset mid-SHIFT, then a clean 0x5A send.
    frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 4, "rst");
    frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 0, "post_rst");

    // Randomized frames against the parity / bit-order model.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] d;
      bit         a;
      int         ones;
      d    = 8'($urandom_range(0, 255));
      a    = 1'($urandom_range(0, 1));
      slow = 1'($urandom_range(0, 1));
      ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(d[b]);
      frame(d, a, (ones % 2) == 0, !a, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", r));
    end
    slow = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
